regfile_access_ctrl: RTL and testbench

//  Initiator side of the regfile port protocol: sequences operand reads and writebacks into the regfile.
//  The regfile writes on posedge clk and reads on negedge clk.

---
 rtl/regfile_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Regfile access controller: sequences operand reads and writebacks,
// forwards same-cycle writes to operand capture, issues post-reset clear.
module regfile_access_ctrl #(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [AWIDTH-1:0] op_rs_addr,
    input  logic [AWIDTH-1:0] op_rt_addr,
    input  logic              op_use_rs,
    input  logic              op_use_rt,
    output logic              opd_valid,
    input  logic              opd_ready,
    output logic [15:0]       opd_rs,
    output logic [15:0]       opd_rt,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [15:0]       wb_data,
    output logic              rf_clear,
    output logic [AWIDTH-1:0] rf_addr_rs,
    output logic              rf_req_rs,
    output logic [AWIDTH-1:0] rf_addr_rt,
    output logic              rf_req_rt,
    output logic [AWIDTH-1:0] rf_addr_rd,
    output logic              rf_req_rd,
    output logic [15:0]       rf_wdata,
    input  logic [15:0]       rf_rs,
    input  logic [15:0]       rf_rt
);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AWIDTH-1:0] r_rs_addr;
    logic [AWIDTH-1:0] r_rt_addr;
    logic              r_use_rs;
    logic              r_use_rt;
    logic [15:0]       r_opd_rs;
    logic [15:0]       r_opd_rt;
    logic              r_wb_valid;
    logic [AWIDTH-1:0] r_wb_addr;
    logic [15:0]       r_wb_data;

    logic              w_op_acc;
    logic              w_wb_acc;
    logic              w_fwd_rs;
    logic              w_fwd_rt;
    logic [15:0]       w_rs_val;
    logic [15:0]       w_rt_val;

    // Next-state and handshake outputs; clear masks every request so nothing
    // is accepted or issued in a cycle that is being reset.
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        wb_ready    = 1'b0;
        rf_clear    = 1'b0;
        opd_valid   = 1'b0;
        rf_req_rs   = 1'b0;
        rf_req_rt   = 1'b0;
        unique case (r_state)
            S_INIT: begin
                rf_clear    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                op_ready = 1'b1;
                wb_ready = 1'b1;
                if (op_valid) w_state_nxt = S_READ;
            end
            S_READ: begin
                wb_ready    = 1'b1;
                rf_req_rs   = r_use_rs;
                rf_req_rt   = r_use_rt;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                wb_ready  = 1'b1;
                opd_valid = 1'b1;
                if (opd_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_INIT;
        endcase
        if (clear) begin
            op_ready  = 1'b0;
            wb_ready  = 1'b0;
            rf_clear  = 1'b0;
            opd_valid = 1'b0;
            rf_req_rs = 1'b0;
            rf_req_rt = 1'b0;
        end
    end

    assign w_op_acc = op_valid & op_ready;
    assign w_wb_acc = wb_valid & wb_ready;

    // Regfile reads the pre-write value on negedge, so a write in flight
    // this cycle must be taken from the holding register instead.
    assign w_fwd_rs = r_wb_valid && (r_wb_addr == r_rs_addr);
    assign w_fwd_rt = r_wb_valid && (r_wb_addr == r_rt_addr);
    assign w_rs_val = !r_use_rs ? 16'h0000 :
                      w_fwd_rs  ? r_wb_data : rf_rs;
    assign w_rt_val = !r_use_rt ? 16'h0000 :
                      w_fwd_rt  ? r_wb_data : rf_rt;

    assign opd_rs     = r_opd_rs;
    assign opd_rt     = r_opd_rt;
    assign rf_addr_rs = r_rs_addr;
    assign rf_addr_rt = r_rt_addr;
    assign rf_addr_rd = r_wb_addr;
    assign rf_wdata   = r_wb_data;
    assign rf_req_rd  = r_wb_valid & ~clear;

    // State register
    always_ff @(posedge clk) begin
        if (clear) r_state <= S_INIT;
        else       r_state <= w_state_nxt;
    end

    // Latch the fetch request on accept
    always_ff @(posedge clk) begin
        if (clear) begin
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_use_rs  <= 1'b0;
            r_use_rt  <= 1'b0;
        end else if (w_op_acc) begin
            r_rs_addr <= op_rs_addr;
            r_rt_addr <= op_rt_addr;
            r_use_rs  <= op_use_rs;
            r_use_rt  <= op_use_rt;
        end
    end

    // Capture operands at the end of READ; hold them through RESP
    always_ff @(posedge clk) begin
        if (clear) begin
            r_opd_rs <= '0;
            r_opd_rt <= '0;
        end else if (r_state == S_READ) begin
            r_opd_rs <= w_rs_val;
            r_opd_rt <= w_rt_val;
        end
    end

    // Writeback holding register: reloads or invalidates every edge
    always_ff @(posedge clk) begin
        if (clear) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_wb_acc;
            if (w_wb_acc) begin
                r_wb_addr <= wb_addr;
                r_wb_data <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural regfile
// (posedge write, negedge read) attached to the rf_* ports.
module tb_regfile_access_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          clear;
    logic          op_valid;
    logic          op_ready;
    logic [AW-1:0] op_rs_addr;
    logic [AW-1:0] op_rt_addr;
    logic          op_use_rs;
    logic          op_use_rt;
    logic          opd_valid;
    logic          opd_ready;
    logic [15:0]   opd_rs;
    logic [15:0]   opd_rt;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [15:0]   wb_data;
    logic          rf_clear;
    logic [AW-1:0] rf_addr_rs;
    logic          rf_req_rs;
    logic [AW-1:0] rf_addr_rt;
    logic          rf_req_rt;
    logic [AW-1:0] rf_addr_rd;
    logic          rf_req_rd;
    logic [15:0]   rf_wdata;
    logic [15:0]   rf_rs = '0;
    logic [15:0]   rf_rt = '0;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.AWIDTH(AW)) dut (
        .clk        (clk),
        .clear      (clear),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_rs_addr (op_rs_addr),
        .op_rt_addr (op_rt_addr),
        .op_use_rs  (op_use_rs),
        .op_use_rt  (op_use_rt),
        .opd_valid  (opd_valid),
        .opd_ready  (opd_ready),
        .opd_rs     (opd_rs),
        .opd_rt     (opd_rt),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_clear   (rf_clear),
        .rf_addr_rs (rf_addr_rs),
        .rf_req_rs  (rf_req_rs),
        .rf_addr_rt (rf_addr_rt),
        .rf_req_rt  (rf_req_rt),
        .rf_addr_rd (rf_addr_rd),
        .rf_req_rd  (rf_req_rd),
        .rf_wdata   (rf_wdata),
        .rf_rs      (rf_rs),
        .rf_rt      (rf_rt)
    );

    // Regfile model: write on posedge
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (rf_req_rd) begin
            mem[rf_addr_rd] <= rf_wdata;
        end
    end

    // Regfile model: read on negedge
    always @(negedge clk) begin
        if (rf_req_rs) rf_rs <= mem[rf_addr_rs];
        if (rf_req_rt) rf_rt <= mem[rf_addr_rt];
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urs, input logic urt);
        op_valid   = 1'b1;
        op_rs_addr = rs;
        op_rt_addr = rt;
        op_use_rs  = urs;
        op_use_rt  = urt;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        clear      = 1'b1;
        op_valid   = 1'b0;
        op_rs_addr = '0;
        op_rt_addr = '0;
        op_use_rs  = 1'b0;
        op_use_rt  = 1'b0;
        opd_ready  = 1'b0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        tick();
        tick();

        // Reset state
        check("rst_rf_clear", rf_clear, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_wb_ready", wb_ready, 0);
        check("rst_opd_valid", opd_valid, 0);
        check("rst_opd_rs", opd_rs, 0);
        check("rst_req_rd", rf_req_rd, 0);
        check("rst_addr_rs", rf_addr_rs, 0);

        // 1: INIT cycle after release
        clear = 1'b0;
        #1;
        check("init_rf_clear", rf_clear, 1);
        check("init_op_ready", op_ready, 0);
        check("init_wb_ready", wb_ready, 0);
        tick();
        check("idle_rf_clear", rf_clear, 0);
        check("idle_op_ready", op_ready, 1);
        check("idle_wb_ready", wb_ready, 1);

        // 2: writeback then fetch
        wb_valid = 1'b1;
        wb_addr  = 8'd5;
        wb_data  = 16'hBEEF;
        tick();
        wb_valid = 1'b0;
        check("t2_req_rd", rf_req_rd, 1);
        check("t2_addr_rd", rf_addr_rd, 5);
        check("t2_wdata", rf_wdata, 16'hBEEF);
        tick();
        check("t2_req_rd_off", rf_req_rd, 0);
        check("t2_mem5", mem[5], 16'hBEEF);
        fetch(8'd5, 8'd0, 1'b1, 1'b0);
        tick();
        op_valid = 1'b0;
        check("t2_read_req_rs", rf_req_rs, 1);
        check("t2_read_addr_rs", rf_addr_rs, 5);
        check("t2_read_req_rt", rf_req_rt, 0);
        check("t2_read_op_ready", op_ready, 0);
        check("t2_read_opd_valid", opd_valid, 0);
        tick();
        check("t2_opd_valid", opd_valid, 1);
        check("t2_opd_rs", opd_rs, 16'hBEEF);
        check("t2_opd_rt", opd_rt, 0);
        opd_ready = 1'b1;
        tick();
        opd_ready = 1'b0;
        check("t2_done_valid", opd_valid, 0);
        check("t2_done_op_ready", op_ready, 1);

        // 3: wb accepted on the edge entering READ is forwarded
        fetch(8'd7, 8'd7, 1'b1, 1'b1);
        wb_valid = 1'b1;
        wb_addr  = 8'd7;
        wb_data  = 16'h1234;
        tick();
        op_valid = 1'b0;
        wb_valid = 1'b0;
        check("t3_read_req_rd", rf_req_rd, 1);
        tick();
        check("t3_opd_rs", opd_rs, 16'h1234);
        check("t3_opd_rt", opd_rt, 16'h1234);
        opd_ready = 1'b1;
        tick();
        opd_ready = 1'b0;

        // 4: rs unused, rt from regfile
        wb_valid = 1'b1;
        wb_addr  = 8'd3;
        wb_data  = 16'h00AA;
        tick();
        wb_valid = 1'b0;
        tick();
        fetch(8'd3, 8'd3, 1'b0, 1'b1);
        tick();
        op_valid = 1'b0;
        check("t4_req_rs", rf_req_rs, 0);
        check("t4_req_rt", rf_req_rt, 1);
        tick();
        check("t4_opd_rs", opd_rs, 0);
        check("t4_opd_rt", opd_rt, 16'h00AA);
        opd_ready = 1'b1;
        tick();
        opd_ready = 1'b0;

        // 5: stall in RESP while wbs overwrite the fetched registers
        fetch(8'd5, 8'd3, 1'b1, 1'b1);
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1;
            wb_addr  = (i % 2 == 0) ? 8'd5 : 8'd3;
            wb_data  = 16'h1000 + 16'(i);
            check("t5_wb_ready", wb_ready, 1);
            tick();
            check("t5_opd_valid", opd_valid, 1);
            check("t5_opd_rs", opd_rs, 16'hBEEF);
            check("t5_opd_rt", opd_rt, 16'h00AA);
            check("t5_op_ready", op_ready, 0);
            check("t5_req_rd", rf_req_rd, 1);
            check("t5_wdata", rf_wdata, 16'h1000 + 16'(i));
        end
        wb_valid  = 1'b0;
        opd_ready = 1'b1;
        tick();
        opd_ready = 1'b0;
        check("t5_mem5", mem[5], 16'h1004);
        check("t5_mem3", mem[3], 16'h1003);
        check("t5_idle", op_ready, 1);

        // 6: clear during READ with a wb pending
        fetch(8'd5, 8'd0, 1'b1, 1'b0);
        tick();
        op_valid = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = 8'd9;
        wb_data  = 16'h5555;
        clear    = 1'b1;
        #1;
        check("t6_wb_ready", wb_ready, 0);
        check("t6_req_rs", rf_req_rs, 0);
        tick();
        check("t6_req_rd", rf_req_rd, 0);
        check("t6_opd_valid", opd_valid, 0);
        clear    = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("t6_init_rf_clear", rf_clear, 1);
        check("t6_init_op_ready", op_ready, 0);
        check("t6_init_req_rd", rf_req_rd, 0);
        tick();
        check("t6_idle_rf_clear", rf_clear, 0);
        check("t6_idle_op_ready", op_ready, 1);
        check("t6_idle_req_rd", rf_req_rd, 0);
        check("t6_idle_opd_valid", opd_valid, 0);
        check("t6_mem9", mem[9], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
